cdb_arbiter: RTL and testbench

- Shares the CDB_WIDTH common-data-bus broadcast slots between NUM_REQ execution-unit writeback ports (ALUs, MUL/DIV, LSU).
- Selects up to CDB_WIDTH winners per cycle with rotating (round-robin) priority and packs them into slots 0..k-1.
- Registers the winners as the CDB broadcast that the bypass network, reservation stations, PRF and ROB consume one cycle later.
- Losing requesters hold their payload under a valid/ready handshake.

---
 rtl/cdb_pkg.sv | 20 ++
 rtl/rr_multi_pick.sv | 44 ++++
 rtl/cdb_arbiter.sv | 98 +++++++++
 tb/tb_cdb_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared common-data-bus types and widths, used by the arbiter, the bypass
// network and the reservation stations.
package cdb_pkg;
  localparam int NUM_PHYS_REGS = 64;
  localparam int ROB_DEPTH     = 32;
  localparam int PREG_BITS     = $clog2(NUM_PHYS_REGS);
  localparam int ROB_BITS      = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [PREG_BITS-1:0] tag;
    logic [31:0]          data;
    logic [ROB_BITS-1:0]  rob;
  } cdb_entry_t;

  // A single requester still needs a 1-bit index.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_multi_pick.sv
// Rotating-priority picker: grants up to CDB_WIDTH requesters starting at
// ptr_i and packs them, in scan order, into slots 0..k-1.
module rr_multi_pick
  import cdb_pkg::*;
#(
  parameter int NUM_REQ   = 6,
  parameter int CDB_WIDTH = 4,
  localparam int IW       = idx_bits(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [IW-1:0]           ptr_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [CDB_WIDTH-1:0]    slot_vld_o,
  output logic [CDB_WIDTH*IW-1:0] slot_idx_o,
  output logic [IW-1:0]           last_o,
  output logic                    any_o
);
  always_comb begin
    int n;
    logic [IW-1:0] idx;
    gnt_o      = '0;
    slot_vld_o = '0;
    slot_idx_o = '0;
    last_o     = '0;
    n          = 0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[idx] && n < CDB_WIDTH) begin
        gnt_o[idx] = 1'b1;
        for (int s = 0; s < CDB_WIDTH; s++) begin
          if (s == n) begin
            slot_vld_o[s]           = 1'b1;
            slot_idx_o[s*IW +: IW]  = idx;
          end
        end
        last_o = idx;
        n++;
      end
    end
  end

  assign any_o = |gnt_o;
endmodule

// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter: round-robin shares CDB_WIDTH broadcast slots among
// NUM_REQ writeback ports and registers the winners as next cycle's broadcast.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int CDB_WIDTH = 4,
  parameter int NUM_REQ   = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*PREG_BITS-1:0]   req_tag,
  input  logic [NUM_REQ*32-1:0]          req_data,
  input  logic [NUM_REQ*ROB_BITS-1:0]    req_rob,
  output logic [CDB_WIDTH-1:0]           cdb_valid,
  output logic [CDB_WIDTH*PREG_BITS-1:0] cdb_tag,
  output logic [CDB_WIDTH*32-1:0]        cdb_data,
  output logic [CDB_WIDTH*ROB_BITS-1:0]  cdb_rob,
  output logic [31:0]                    conflict_cnt
);
  localparam int IW = idx_bits(NUM_REQ);

  logic [NUM_REQ-1:0]      tag0, slot_req, gnt;
  logic [CDB_WIDTH-1:0]    slot_vld;
  logic [CDB_WIDTH*IW-1:0] slot_idx;
  logic [IW-1:0]           last, ptr_q, ptr_d;
  logic                    any_gnt, refused;
  logic [31:0]             conflict_cnt_q, conflict_cnt_d;
  cdb_entry_t [CDB_WIDTH-1:0] cdb_q, cdb_d;

  always_comb begin
    tag0 = '0;
    for (int i = 0; i < NUM_REQ; i++)
      tag0[i] = (req_tag[i*PREG_BITS +: PREG_BITS] == '0);
  end

  // Tag-0 results need no slot, so they bypass the picker entirely.
  assign slot_req = req_valid & ~tag0 & {NUM_REQ{~flush}};

  rr_multi_pick #(.NUM_REQ(NUM_REQ), .CDB_WIDTH(CDB_WIDTH)) u_pick (
    .req_i      (slot_req),
    .ptr_i      (ptr_q),
    .gnt_o      (gnt),
    .slot_vld_o (slot_vld),
    .slot_idx_o (slot_idx),
    .last_o     (last),
    .any_o      (any_gnt)
  );

  assign req_ready = (rst || flush) ? '0 : (req_valid & (tag0 | gnt));
  assign refused   = ~flush & |(req_valid & ~req_ready);

  always_comb begin
    cdb_d = '0;
    for (int s = 0; s < CDB_WIDTH; s++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (slot_vld[s] && slot_idx[s*IW +: IW] == IW'(r)) begin
          cdb_d[s].valid = 1'b1;
          cdb_d[s].tag   = req_tag[r*PREG_BITS +: PREG_BITS];
          cdb_d[s].data  = req_data[r*32 +: 32];
          cdb_d[s].rob   = req_rob[r*ROB_BITS +: ROB_BITS];
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt)
      ptr_d = (last == IW'(NUM_REQ-1)) ? '0 : last + 1'b1;
    conflict_cnt_d = conflict_cnt_q;
    if (refused && conflict_cnt_q != '1)
      conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_q          <= '0;
      ptr_q          <= '0;
      conflict_cnt_q <= '0;
    end else begin
      cdb_q          <= cdb_d;
      ptr_q          <= ptr_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  for (genvar s = 0; s < CDB_WIDTH; s++) begin : g_out
    assign cdb_valid[s]                         = cdb_q[s].valid;
    assign cdb_tag[s*PREG_BITS +: PREG_BITS]    = cdb_q[s].tag;
    assign cdb_data[s*32 +: 32]                 = cdb_q[s].data;
    assign cdb_rob[s*ROB_BITS +: ROB_BITS]      = cdb_q[s].rob;
  end

  assign conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic, checked
// against a queue-free round-robin reference model.
module tb_cdb_arbiter;
  localparam int N  = 6;
  localparam int W  = 4;
  localparam int PB = 6;
  localparam int RB = 5;

  logic clk = 1'b0, rst, flush;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*PB-1:0] req_tag;
  logic [N*32-1:0] req_data;
  logic [N*RB-1:0] req_rob;
  logic [W-1:0]    cdb_valid;
  logic [W*PB-1:0] cdb_tag;
  logic [W*32-1:0] cdb_data;
  logic [W*RB-1:0] cdb_rob;
  logic [31:0]     conflict_cnt;

  cdb_arbiter #(.CDB_WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_data(req_data), .req_rob(req_rob),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_rob(cdb_rob), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // requester state
  bit          tv[N];
  logic [5:0]  tt[N];
  logic [31:0] td[N];
  logic [4:0]  tr[N];
  int          age[N];

  always_comb begin
    req_valid = '0; req_tag = '0; req_data = '0; req_rob = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = tv[i];
      req_tag[i*PB +: PB]   = tt[i];
      req_data[i*32 +: 32]  = td[i];
      req_rob[i*RB +: RB]   = tr[i];
    end
  end

  // reference model state and expectations
  int          m_ptr;
  logic [31:0] m_cnt;
  logic [N-1:0]    e_rdy, obs_rdy;
  logic [W-1:0]    e_v;
  logic [W*PB-1:0] e_tag;
  logic [W*32-1:0] e_data;
  logic [W*RB-1:0] e_rob;
  int errs = 0, checks = 0, cyc = 0;

  task automatic check(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [5:0] t, input logic [31:0] d, input logic [4:0] r);
    tv[i] = 1'b1; tt[i] = t; td[i] = d; tr[i] = r; age[i] = 0;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) tv[i] = 1'b0;
  endtask

  task automatic refill(input bit all_nz, input int pct);
    for (int i = 0; i < N; i++)
      if (!tv[i] && $urandom_range(0, 99) < pct) begin
        logic [5:0] t;
        t = 6'($urandom_range(0, 63));
        if (all_nz && t == 0) t = 6'd1;
        if (!all_nz && $urandom_range(0, 4) == 0) t = 6'd0;
        set_req(i, t, $urandom, 5'($urandom_range(0, 31)));
      end
  endtask

  // One clock: drive at negedge, check ready, advance model, check broadcast.
  task automatic step(input bit fl);
    int k, last;
    bit refused;
    flush = fl;
    #1;
    e_rdy = '0; e_v = '0; e_tag = '0; e_data = '0; e_rob = '0;
    k = 0; last = -1; refused = 1'b0;
    for (int j = 0; j < N; j++) begin
      automatic int i = (m_ptr + j) % N;
      if (tv[i] && !fl) begin
        if (tt[i] == 0) e_rdy[i] = 1'b1;
        else if (k < W) begin
          e_rdy[i] = 1'b1; e_v[k] = 1'b1;
          e_tag[k*PB +: PB] = tt[i]; e_data[k*32 +: 32] = td[i]; e_rob[k*RB +: RB] = tr[i];
          k++; last = i;
        end else refused = 1'b1;
      end
    end
    check("req_ready", req_ready, e_rdy);
    obs_rdy = req_ready;
    @(posedge clk);
    if (last >= 0) m_ptr = (last + 1) % N;
    if (refused && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    @(negedge clk);
    cyc++;
    flush = 1'b0;
    check("cdb_valid", cdb_valid, e_v);
    check("cdb_tag", cdb_tag, e_tag);
    check("cdb_data", cdb_data, e_data);
    check("cdb_rob", cdb_rob, e_rob);
    check("conflict_cnt", conflict_cnt, m_cnt);
    for (int i = 0; i < N; i++) begin
      if (!tv[i]) continue;
      if (fl) begin tv[i] = 1'b0; continue; end
      if (tt[i] != 0) age[i]++;
      if (obs_rdy[i]) begin
        if (tt[i] != 0) check("fair_grant_age", 128'(age[i] <= 2), 128'(1));
        tv[i] = 1'b0;
      end else if (tt[i] != 0) check("fair_wait_age", 128'(age[i] <= 1), 128'(1));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    for (int i = 0; i < N; i++) begin tv[i] = 0; tt[i] = 0; td[i] = 0; tr[i] = 0; age[i] = 0; end
    m_ptr = 0; m_cnt = 0;
    repeat (2) @(negedge clk);
    // reset holds ready low even with valid requesters
    set_req(0, 6'd3, 32'h1, 5'd1); set_req(1, 6'd0, 32'h2, 5'd2);
    #1;
    check("rst_ready", req_ready, '0);
    check("rst_cdb_valid", cdb_valid, '0);
    check("rst_cnt", conflict_cnt, '0);
    idle_all();
    @(negedge clk); rst = 1'b0;

    // light load
    set_req(1, 6'd5, 32'hA, 5'd3); set_req(3, 6'd9, 32'hB, 5'd4);
    step(0);
    check("light_ready", obs_rdy, 6'b001010);
    check("light_valid", cdb_valid, 4'b0011);
    // ptr is now 4: a lone grant to req 5 brings it back to 0
    set_req(5, 6'd3, 32'h55, 5'd5);
    step(0);

    // oversubscription, all six held
    for (int i = 0; i < N; i++) set_req(i, 6'(10 + i), 32'h100 + i, 5'(i));
    step(0);
    check("over1_ready", obs_rdy, 6'b001111);
    check("over1_cnt", conflict_cnt, 32'd1);
    for (int i = 0; i < 4; i++) set_req(i, 6'(20 + i), 32'h200 + i, 5'(8 + i));
    step(0);
    check("over2_ready", obs_rdy, 6'b110011);
    check("over2_tags", cdb_tag, {6'd21, 6'd20, 6'd15, 6'd14});

    // asynchronous reset mid-cycle with a broadcast pending
    rst = 1'b1;
    #1;
    check("midrst_valid", cdb_valid, '0);
    check("midrst_data", cdb_data, '0);
    check("midrst_ready", req_ready, '0);
    check("midrst_cnt", conflict_cnt, '0);
    m_ptr = 0; m_cnt = 0; idle_all();
    @(negedge clk); rst = 1'b0;

    // tag-0 requester alongside four slot users
    set_req(2, 6'd0, 32'hDEAD, 5'd7);
    set_req(0, 6'd11, 32'h10, 5'd1); set_req(1, 6'd12, 32'h11, 5'd2);
    set_req(3, 6'd13, 32'h13, 5'd3); set_req(4, 6'd14, 32'h14, 5'd4);
    step(0);
    check("tag0_ready", obs_rdy[2], 1'b1);

    // flush kills the grant and leaves ptr alone
    set_req(0, 6'd7, 32'h77, 5'd9);
    step(1);
    check("flush_ready", obs_rdy, '0);
    check("flush_valid", cdb_valid, '0);
    set_req(0, 6'd7, 32'h78, 5'd9); set_req(5, 6'd8, 32'h79, 5'd10);
    step(0);

    // counter saturation
    force dut.conflict_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    for (int c = 0; c < 3; c++) begin
      refill(1'b1, 100);
      step(0);
    end
    check("sat_cnt", conflict_cnt, 32'hFFFF_FFFF);

    // random traffic
    idle_all();
    for (int c = 0; c < 400; c++) begin
      refill(1'b0, 60);
      step($urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
